spi_flash_arbiter: RTL and testbench

//  Shares one spi_flash_reader command port (addr/len/go/rdy, data/valid) among
//  N_REQ requesters (e.g. frame loader, palette loader, config fetch).

---
 rtl/spi_flash_arbiter.sv | 104 ++++++++++
 tb/tb_spi_flash_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter that shares one spi_flash_reader command port among
// N_REQ requesters and routes returned bytes back with a one-hot valid.
module spi_flash_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [24*N_REQ-1:0]   req_addr,
  input  logic [16*N_REQ-1:0]   req_len,
  output logic [N_REQ-1:0]      req_ready,
  output logic [7:0]            resp_data,
  output logic [N_REQ-1:0]      resp_valid,
  output logic                  resp_last,
  output logic                  busy,
  output logic [23:0]           fr_addr,
  output logic [15:0]           fr_len,
  output logic                  fr_go,
  input  logic                  fr_rdy,
  input  logic [7:0]            fr_data,
  input  logic                  fr_valid
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic [PW-1:0]   cand;
  logic            found;
  logic [15:0]     cnt;
  int              idx;

  // Cyclic priority search starting at rr_ptr; first requester found wins.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % N_REQ;
      cand = PW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   if (fr_rdy) state_next = XFER;
      XFER:    if (fr_valid && cnt == 16'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant latching and response routing; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      owner      <= '0;
      cnt        <= '0;
      fr_addr    <= '0;
      fr_len     <= '0;
      req_ready  <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
      resp_last  <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      resp_last  <= 1'b0;
      if (state == IDLE && found) begin
        owner     <= win;
        fr_addr   <= req_addr[24*win +: 24];
        fr_len    <= req_len[16*win +: 16];
        cnt       <= req_len[16*win +: 16];
        req_ready <= N_REQ'(1) << win;
        rr_ptr    <= (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
      end
      if (state == XFER && fr_valid) begin
        resp_data  <= fr_data;
        resp_valid <= N_REQ'(1) << owner;
        resp_last  <= (cnt == 16'd0);
        cnt        <= cnt - 16'd1;
      end
    end
  end

  assign fr_go = (state == ISSUE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter with a behavioural flash reader
// (rdy high when idle, one byte every 4 clocks, data = addr[7:0] + k).
module tb_spi_flash_arbiter;

  logic         clk;
  logic         rst;
  logic [2:0]   req_valid;
  logic [71:0]  req_addr;
  logic [47:0]  req_len;
  logic [2:0]   req_ready;
  logic [7:0]   resp_data;
  logic [2:0]   resp_valid;
  logic         resp_last;
  logic         busy;
  logic [23:0]  fr_addr;
  logic [15:0]  fr_len;
  logic         fr_go;
  logic         fr_rdy;
  logic [7:0]   fr_data;
  logic         fr_valid;

  logic [2:0]   reissue;
  int           testsRun;
  int           testsFailed;

  typedef struct packed {
    logic [2:0] oh;
    logic       last;
    logic [7:0] data;
  } resp_t;

  resp_t        expResp[$];
  logic [2:0]   expGrant[$];

  spi_flash_arbiter #(.N_REQ(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_last(resp_last), .busy(busy),
    .fr_addr(fr_addr), .fr_len(fr_len), .fr_go(fr_go),
    .fr_rdy(fr_rdy), .fr_data(fr_data), .fr_valid(fr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural flash reader
  logic         rdActive;
  logic [1:0]   rdTimer;
  logic [16:0]  rdK;
  logic [7:0]   rdAddr;
  logic [15:0]  rdLen;

  assign fr_rdy = !rdActive;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdActive <= 1'b0;
      rdTimer  <= 2'd0;
      rdK      <= 17'd0;
      rdAddr   <= 8'd0;
      rdLen    <= 16'd0;
      fr_valid <= 1'b0;
      fr_data  <= 8'd0;
    end else begin
      fr_valid <= 1'b0;
      if (!rdActive) begin
        if (fr_go && fr_rdy) begin
          rdActive <= 1'b1;
          rdAddr   <= fr_addr[7:0];
          rdLen    <= fr_len;
          rdK      <= 17'd0;
          rdTimer  <= 2'd0;
        end
      end else if (rdTimer == 2'd3) begin
        fr_valid <= 1'b1;
        fr_data  <= rdAddr + rdK[7:0];
        rdK      <= rdK + 17'd1;
        rdTimer  <= 2'd0;
        if (rdK == {1'b0, rdLen}) rdActive <= 1'b0;
      end else begin
        rdTimer <= rdTimer + 2'd1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input int i, input logic [23:0] addr, input logic [15:0] len);
    resp_t e;
    expGrant.push_back(3'b001 << i);
    for (int k = 0; k <= int'(len); k++) begin
      e.oh   = 3'b001 << i;
      e.last = (k == int'(len));
      e.data = addr[7:0] + 8'(k);
      expResp.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [23:0] addr, input logic [15:0] len);
    req_addr[24*i +: 24] = addr;
    req_len[16*i +: 16]  = len;
    req_valid[i]         = 1'b1;
    pushExpect(i, addr, len);
  endtask

  // One cycle: compare grants and responses against the scoreboard, then
  // behave like requesters (drop on grant, re-raise if reissuing).
  task automatic tick();
    resp_t e;
    @(negedge clk);
    if (req_ready != 3'b000) begin
      if (expGrant.size() == 0) checkOutput("unexpected grant", 32'(req_ready), 32'd0);
      else checkOutput("grant", 32'(req_ready), 32'(expGrant.pop_front()));
    end
    if (resp_valid != 3'b000) begin
      if (expResp.size() == 0) begin
        checkOutput("stray resp", 32'({resp_valid, resp_last, resp_data}), 32'd0);
      end else begin
        e = expResp.pop_front();
        checkOutput("resp", 32'({resp_valid, resp_last, resp_data}), 32'(e));
      end
    end
    req_valid = (req_valid & ~req_ready) | (reissue & req_ready);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((expResp.size() != 0 || expGrant.size() != 0 || busy || req_valid != 3'b000) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) checkOutput("timeout", 32'd1, 32'd0);
  endtask

  task automatic applyReset();
    rst       = 1'b1;
    req_valid = 3'b000;
    reissue   = 3'b000;
    expResp.delete();
    expGrant.delete();
    repeat (3) @(negedge clk);
    checkOutput("reset outs", 32'({busy, fr_go, req_ready, resp_valid, resp_last, resp_data}), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    req_valid   = 3'b000;
    req_addr    = '0;
    req_len     = '0;
    reissue     = 3'b000;

    // Single byte from requester 0
    applyReset();
    applyStimulus(0, 24'h00BABE, 16'd0);
    tick();
    checkOutput("fr_go issue", 32'(fr_go), 32'd1);
    checkOutput("fr_addr", 32'(fr_addr), 32'h00BABE);
    checkOutput("busy issue", 32'(busy), 32'd1);
    tick();
    checkOutput("fr_go drop", 32'(fr_go), 32'd0);
    waitIdle(100);
    checkOutput("busy end", 32'(busy), 32'd0);

    // Three simultaneous requests granted 0,1,2
    applyReset();
    applyStimulus(0, 24'h000100, 16'd0);
    applyStimulus(1, 24'h000255, 16'd0);
    applyStimulus(2, 24'h0003A0, 16'd0);
    waitIdle(200);

    // Four-byte burst on requester 1
    applyStimulus(1, 24'h000010, 16'd3);
    waitIdle(200);
    checkOutput("fr_len held", 32'(fr_len), 32'd3);

    // Round-robin with requester 0 continuously asserting
    applyReset();
    reissue = 3'b001;
    applyStimulus(0, 24'h000020, 16'd0);
    tick();
    applyStimulus(2, 24'h000030, 16'd0);
    pushExpect(0, 24'h000020, 16'd0);
    n = 0;
    while (expGrant.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkOutput("rr timeout", 32'd1, 32'd0);
    reissue   = 3'b000;
    req_valid = 3'b000;
    waitIdle(200);

    // Reset in the middle of an 8-byte burst
    applyReset();
    applyStimulus(1, 24'h000040, 16'd7);
    n = 0;
    while (expResp.size() > 5 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) checkOutput("mid-burst timeout", 32'd1, 32'd0);
    checkOutput("busy mid-burst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async reset outs", 32'({busy, fr_go, req_ready, resp_valid, resp_last, resp_data}), 32'd0);
    checkOutput("async reset fr_addr", 32'(fr_addr), 32'd0);
    checkOutput("async reset fr_len", 32'(fr_len), 32'd0);
    expResp.delete();
    expGrant.delete();
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    checkOutput("post-reset busy", 32'(busy), 32'd0);

    // Quiet period with no requests
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle quiet", 32'({fr_go, req_ready, resp_valid}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
